// File: rtl/esm_pkg.sv
// Shared sizing and instruction-field layout for the ESM dependency scheduler.
package esm_pkg;
  localparam int IW_DEF     = 32;
  localparam int REGNUM_DEF = 32;
  localparam int BS_DEF     = 16;
  localparam int RA_DEF     = $clog2(REGNUM_DEF);
  localparam int BI_DEF     = $clog2(BS_DEF);

  localparam int RS1_LSB = 15;
  localparam int RS2_LSB = 20;
  localparam int RD_LSB  = 7;
endpackage

// File: rtl/esm_reg_writer_table.sv
// Last-writer table: maps each architectural register to the window slot that will produce it.
module esm_reg_writer_table
  import esm_pkg::*;
#(
  parameter int REGNUM = REGNUM_DEF,
  parameter int BS     = BS_DEF,
  localparam int RA    = $clog2(REGNUM),
  localparam int BI    = $clog2(BS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2:0][RA-1:0]   look_reg,
  input  logic [2:0]           look_en,
  output logic [2:0][BS-1:0]   look_mask,
  input  logic                 upd_en,
  input  logic [RA-1:0]        upd_reg,
  input  logic [BI-1:0]        upd_idx,
  input  logic                 clr_en,
  input  logic [BI-1:0]        clr_idx
);

  logic [REGNUM-1:0] wr_v;
  logic [BI-1:0]     wr_idx [REGNUM];

  // Register 0 is hardwired, so it never produces a dependency.
  always_comb begin
    for (int p = 0; p < 3; p++) begin
      look_mask[p] = '0;
      if (look_en[p] && look_reg[p] != '0 && wr_v[look_reg[p]])
        look_mask[p][wr_idx[look_reg[p]]] = 1'b1;
    end
  end

  // A same-edge update beats the completion clear for the same register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_v <= '0;
    end else begin
      for (int r = 0; r < REGNUM; r++)
        if (clr_en && wr_v[r] && wr_idx[r] == clr_idx)
          wr_v[r] <= 1'b0;
      if (upd_en)
        wr_v[upd_reg] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (upd_en)
      wr_idx[upd_reg] <= upd_idx;
  end

endmodule

// File: rtl/esm_dep_scheduler.sv
// Instruction-window scheduler: tracks RAW/WAW dependencies per slot and issues one ready entry per cycle round-robin.
module esm_dep_scheduler
  import esm_pkg::*;
#(
  parameter int IW     = IW_DEF,
  parameter int REGNUM = REGNUM_DEF,
  parameter int BS     = BS_DEF,
  localparam int RA    = $clog2(REGNUM),
  localparam int BI    = $clog2(BS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          alloc_valid,
  output logic          alloc_ready,
  input  logic [IW-1:0] alloc_instr,
  input  logic          alloc_use_rs2,
  input  logic          alloc_writes_rd,
  output logic [BI-1:0] alloc_index,
  output logic          issue_valid,
  input  logic          issue_ready,
  output logic [BI-1:0] issue_index,
  input  logic          complete_valid,
  input  logic [BI-1:0] complete_index,
  output logic [BI:0]   occupancy,
  output logic          full,
  output logic          empty
);

  logic [BS-1:0]      valid, issued, cand, comp_mask, new_row;
  logic [BS-1:0]      dep [BS];
  logic [BI-1:0]      rr;
  logic [RA-1:0]      rs1, rs2, rd;
  logic [2:0][BS-1:0] look_mask;
  logic               alloc_fire, issue_fire, comp_fire, found;
  logic               instr_unused;

  assign rs1 = alloc_instr[RS1_LSB +: RA];
  assign rs2 = alloc_instr[RS2_LSB +: RA];
  assign rd  = alloc_instr[RD_LSB +: RA];
  assign instr_unused = ^alloc_instr;

  assign alloc_fire = alloc_valid && alloc_ready;
  assign issue_fire = issue_valid && issue_ready;
  assign comp_fire  = complete_valid && valid[complete_index];
  assign comp_mask  = comp_fire ? (BS'(1) << complete_index) : '0;
  assign new_row    = (look_mask[0] | look_mask[1] | look_mask[2]) & ~comp_mask;

  esm_reg_writer_table #(.REGNUM(REGNUM), .BS(BS)) u_writer_table (
    .clk       (clk),
    .rst       (rst),
    .look_reg  ({rd, rs2, rs1}),
    .look_en   ({alloc_writes_rd, alloc_use_rs2, 1'b1}),
    .look_mask (look_mask),
    .upd_en    (alloc_fire && alloc_writes_rd && rd != '0),
    .upd_reg   (rd),
    .upd_idx   (alloc_index),
    .clr_en    (comp_fire),
    .clr_idx   (complete_index)
  );

  // Occupancy and lowest-free slot from registered valid bits.
  always_comb begin
    occupancy   = '0;
    alloc_index = '0;
    for (int i = 0; i < BS; i++)
      occupancy = occupancy + {{BI{1'b0}}, valid[i]};
    for (int i = BS - 1; i >= 0; i--)
      if (!valid[i]) alloc_index = BI'(i);
  end

  assign full        = (occupancy == (BI + 1)'(BS));
  assign empty       = (occupancy == '0);
  assign alloc_ready = !full;

  // Round-robin: first candidate at or after rr, wrapping.
  always_comb begin
    found       = 1'b0;
    issue_index = '0;
    for (int i = 0; i < BS; i++)
      cand[i] = valid[i] && !issued[i] && (dep[i] == '0);
    for (int k = 0; k < BS; k++) begin
      if (!found && cand[(int'(rr) + k) % BS]) begin
        found       = 1'b1;
        issue_index = BI'((int'(rr) + k) % BS);
      end
    end
    issue_valid = found;
  end

  // Issue, then completion (wins on same entry), then allocation into a slot free before the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid  <= '0;
      issued <= '0;
      rr     <= '0;
      for (int i = 0; i < BS; i++) dep[i] <= '0;
    end else begin
      if (issue_fire) begin
        issued[issue_index] <= 1'b1;
        rr <= (issue_index == BI'(BS - 1)) ? '0 : issue_index + 1'b1;
      end
      if (comp_fire) begin
        valid[complete_index]  <= 1'b0;
        issued[complete_index] <= 1'b0;
        for (int i = 0; i < BS; i++) dep[i][complete_index] <= 1'b0;
      end
      if (alloc_fire) begin
        valid[alloc_index]  <= 1'b1;
        issued[alloc_index] <= 1'b0;
        dep[alloc_index]    <= new_row;
      end
    end
  end

endmodule

// File: tb/tb_esm_dep_scheduler.sv
// Randomised and directed bench for esm_dep_scheduler against a set/array-based window model.
module tb_esm_dep_scheduler;
  localparam int BS = 16;
  localparam int NREG = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        alloc_valid, alloc_ready, alloc_use_rs2, alloc_writes_rd;
  logic [31:0] alloc_instr;
  logic [3:0]  alloc_index, issue_index, complete_index;
  logic        issue_valid, issue_ready, complete_valid;
  logic [4:0]  occupancy;
  logic        full, empty;

  esm_dep_scheduler dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_instr(alloc_instr),
    .alloc_use_rs2(alloc_use_rs2), .alloc_writes_rd(alloc_writes_rd), .alloc_index(alloc_index),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_index(issue_index),
    .complete_valid(complete_valid), .complete_index(complete_index),
    .occupancy(occupancy), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  bit m_valid [BS];
  bit m_issued[BS];
  bit m_dep   [BS][BS];
  int m_writer[NREG];
  int m_rr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input int rd, input int rs1, input int rs2);
    return {7'd0, 5'(rs2), 5'(rs1), 3'd0, 5'(rd), 7'h13};
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < BS; i++) begin
      m_valid[i] = 0; m_issued[i] = 0;
      for (int j = 0; j < BS; j++) m_dep[i][j] = 0;
    end
    for (int r = 0; r < NREG; r++) m_writer[r] = -1;
    m_rr = 0;
  endfunction

  function automatic int m_occ();
    int n = 0;
    for (int i = 0; i < BS; i++) n += int'(m_valid[i]);
    return n;
  endfunction

  function automatic int m_free();
    for (int i = 0; i < BS; i++) if (!m_valid[i]) return i;
    return 0;
  endfunction

  function automatic bit m_ready(input int e);
    if (!m_valid[e] || m_issued[e]) return 0;
    for (int j = 0; j < BS; j++) if (m_dep[e][j]) return 0;
    return 1;
  endfunction

  function automatic int m_pick();
    for (int k = 0; k < BS; k++) if (m_ready((m_rr + k) % BS)) return (m_rr + k) % BS;
    return -1;
  endfunction

  task automatic step(input bit av, input logic [31:0] ins, input bit u2, input bit wr,
                      input bit ir, input bit cv, input int ci);
    int occ, pick, s, rs1, rs2, rd;
    bit fa, fi, fc;
    bit row[BS];
    @(negedge clk);
    alloc_valid = av; alloc_instr = ins; alloc_use_rs2 = u2; alloc_writes_rd = wr;
    issue_ready = ir; complete_valid = cv; complete_index = 4'(ci);
    occ  = m_occ();
    pick = m_pick();
    chk("occupancy", 32'(occupancy), occ);
    chk("full", 32'(full), 32'(occ == BS));
    chk("empty", 32'(empty), 32'(occ == 0));
    chk("alloc_ready", 32'(alloc_ready), 32'(occ < BS));
    if (occ < BS) chk("alloc_index", 32'(alloc_index), m_free());
    chk("issue_valid", 32'(issue_valid), 32'(pick >= 0));
    if (pick >= 0) chk("issue_index", 32'(issue_index), pick);
    @(posedge clk);
    fa = av && occ < BS;
    s  = m_free();
    fi = ir && pick >= 0;
    fc = cv && m_valid[ci];
    rs1 = int'(ins[19:15]); rs2 = int'(ins[24:20]); rd = int'(ins[11:7]);
    for (int j = 0; j < BS; j++) row[j] = 0;
    if (rs1 != 0 && m_writer[rs1] >= 0) row[m_writer[rs1]] = 1;
    if (u2 && rs2 != 0 && m_writer[rs2] >= 0) row[m_writer[rs2]] = 1;
    if (wr && rd != 0 && m_writer[rd] >= 0) row[m_writer[rd]] = 1;
    if (fc) row[ci] = 0;
    if (fi) begin
      m_issued[pick] = 1;
      m_rr = (pick + 1) % BS;
    end
    if (fc) begin
      m_valid[ci] = 0; m_issued[ci] = 0;
      for (int e = 0; e < BS; e++) m_dep[e][ci] = 0;
      for (int r = 0; r < NREG; r++) if (m_writer[r] == ci) m_writer[r] = -1;
    end
    if (fa) begin
      m_valid[s] = 1; m_issued[s] = 0;
      for (int j = 0; j < BS; j++) m_dep[s][j] = row[j];
      if (wr && rd != 0) m_writer[rd] = s;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    alloc_valid = 0; issue_ready = 0; complete_valid = 0;
    m_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int cands[$];
    rst = 1'b1;
    alloc_valid = 0; alloc_instr = '0; alloc_use_rs2 = 0; alloc_writes_rd = 0;
    issue_ready = 0; complete_valid = 0; complete_index = '0;
    m_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_alloc_ready", 32'(alloc_ready), 1);
    chk("rst_alloc_index", 32'(alloc_index), 0);
    chk("rst_issue_valid", 32'(issue_valid), 0);
    chk("rst_issue_index", 32'(issue_index), 0);
    chk("rst_occupancy", 32'(occupancy), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);

    // addi x1, x0 -> slot 0, issuable next cycle
    step(1, mk(1, 0, 0), 0, 1, 0, 0, 0);
    #1;
    chk("t1_issue_valid", 32'(issue_valid), 1);
    chk("t1_issue_index", 32'(issue_index), 0);

    // RAW chain: add x2,x1,x1 waits for slot 0 to complete
    do_reset();
    step(1, mk(1, 0, 0), 0, 1, 0, 0, 0);
    step(1, mk(2, 1, 1), 1, 1, 1, 0, 0);
    step(0, '0, 0, 0, 1, 0, 0);
    #1;
    chk("t2_blocked", 32'(issue_valid), 0);
    step(0, '0, 0, 0, 0, 1, 0);
    #1;
    chk("t2_released_valid", 32'(issue_valid), 1);
    chk("t2_released_index", 32'(issue_index), 1);

    // fill the window, extra allocation ignored, then drain issues in order
    do_reset();
    for (int i = 0; i < BS + 1; i++) step(1, mk(0, 0, 0), 0, 0, 0, 0, 0);
    #1;
    chk("t3_full", 32'(full), 1);
    chk("t3_alloc_ready", 32'(alloc_ready), 0);
    chk("t3_occupancy", 32'(occupancy), 16);
    for (int i = 0; i < 6; i++) step(0, '0, 0, 0, 1, 1, 3 * i);
    for (int i = 0; i < 14; i++) step(1, mk(0, 0, 0), 0, 0, 1, 1, i);

    // same-edge alloc reading x5 while x5's writer completes
    do_reset();
    step(1, mk(5, 0, 0), 0, 1, 0, 0, 0);
    step(0, '0, 0, 0, 1, 0, 0);
    step(1, mk(6, 5, 0), 0, 1, 0, 1, 0);
    #1;
    chk("t5_issue_valid", 32'(issue_valid), 1);
    chk("t5_issue_index", 32'(issue_index), 1);
    step(1, mk(7, 5, 0), 0, 1, 0, 0, 0);

    // reset mid-operation with 5 entries, 2 issued
    do_reset();
    for (int i = 0; i < 5; i++) step(1, mk(i + 1, 0, 0), 0, 1, 0, 0, 0);
    step(0, '0, 0, 0, 1, 0, 0);
    step(0, '0, 0, 0, 1, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    m_reset();
    #1;
    chk("t6_occupancy", 32'(occupancy), 0);
    chk("t6_issue_valid", 32'(issue_valid), 0);
    chk("t6_alloc_index", 32'(alloc_index), 0);
    @(negedge clk);
    rst = 1'b0;

    // randomised traffic on a small register subset to force dependencies
    for (int n = 0; n < 3000; n++) begin
      bit av, u2, wr, ir, cv;
      int ci;
      av = $urandom_range(0, 99) < 60;
      u2 = $urandom_range(0, 1) == 1;
      wr = $urandom_range(0, 3) != 0;
      ir = $urandom_range(0, 99) < 70;
      cands.delete();
      for (int e = 0; e < BS; e++) if (m_valid[e] && m_issued[e]) cands.push_back(e);
      cv = 0; ci = 0;
      if (cands.size() > 0 && $urandom_range(0, 1) == 1) begin
        cv = 1; ci = cands[$urandom_range(0, cands.size() - 1)];
      end else if ($urandom_range(0, 19) == 0) begin
        cv = 1; ci = $urandom_range(0, BS - 1);
      end
      step(av, mk($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7)),
           u2, wr, ir, cv, ci);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
